// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: drives next PC, captures the IF/ID register,
// and tracks fetch/bubble statistics across BOOT, RUN and HALTED states.
module fetch_ctrl #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_out,
  input  logic [31:0] instr_in,
  input  logic        stall,
  input  logic        halt,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic [31:0] pc_in,
  output logic [31:0] if_id_pc,
  output logic [31:0] if_id_instr,
  output logic        if_id_valid,
  output logic [31:0] fetch_count,
  output logic [15:0] bubble_count,
  output logic        misalign_err,
  output logic [1:0]  fetch_state
);

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] redirect_aligned;
  logic        redirect_misaligned;
  logic [15:0] bubble_next;

  assign redirect_aligned    = {redirect_target[31:2], 2'b00};
  assign redirect_misaligned = (redirect_target[1:0] != 2'b00);
  assign bubble_next         = (bubble_count == 16'hFFFF) ? bubble_count : bubble_count + 16'd1;
  assign fetch_state         = state;

  // Next-PC select; the unused encoding falls into the BOOT path.
  always_comb begin
    pc_in = RESET_VECTOR;
    if (!reset) begin
      case (state)
        ST_RUN: begin
          if (redirect_valid)
            pc_in = redirect_aligned;
          else if (halt || stall)
            pc_in = pc_out;
          else
            pc_in = pc_out + 32'd4;
        end
        ST_HALTED: begin
          if (redirect_valid)
            pc_in = redirect_aligned;
          else
            pc_in = pc_out;
        end
        default: pc_in = RESET_VECTOR;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= ST_BOOT;
      if_id_pc     <= 32'd0;
      if_id_instr  <= 32'd0;
      if_id_valid  <= 1'b0;
      fetch_count  <= 32'd0;
      bubble_count <= 16'd0;
      misalign_err <= 1'b0;
    end else begin
      case (state)
        ST_RUN: begin
          if (redirect_valid) begin
            // Wrong-path instruction is killed; stall/halt are ignored this cycle.
            if_id_valid  <= 1'b0;
            bubble_count <= bubble_next;
            if (redirect_misaligned)
              misalign_err <= 1'b1;
          end else if (halt) begin
            if_id_valid <= 1'b0;
            state       <= ST_HALTED;
          end else if (stall) begin
            bubble_count <= bubble_next;
          end else begin
            if_id_pc    <= pc_out;
            if_id_instr <= instr_in;
            if_id_valid <= 1'b1;
            fetch_count <= fetch_count + 32'd1;
          end
        end
        ST_HALTED: begin
          if_id_valid <= 1'b0;
          if (redirect_valid) begin
            bubble_count <= bubble_next;
            state        <= ST_RUN;
            if (redirect_misaligned)
              misalign_err <= 1'b1;
          end
        end
        default: begin
          if_id_valid <= 1'b0;
          state       <= ST_RUN;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Directed bench for fetch_ctrl: models the external PC register and a
// combinational instruction memory, then checks a vector table and corner cases.
module tb_fetch_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] pc_out;
  logic [31:0] instr_in;
  logic        stall, halt, redirect_valid;
  logic [31:0] redirect_target;
  logic [31:0] pc_in, if_id_pc, if_id_instr, fetch_count;
  logic        if_id_valid, misalign_err;
  logic [15:0] bubble_count;
  logic [1:0]  fetch_state;

  logic [31:0] pc_q;
  logic        ovr_en;
  logic [31:0] ovr_val;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  always @(posedge clk) pc_q <= pc_in;

  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  assign pc_out   = ovr_en ? ovr_val : pc_q;
  assign instr_in = imem(pc_out);

  fetch_ctrl #(.RESET_VECTOR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .pc_out(pc_out), .instr_in(instr_in),
    .stall(stall), .halt(halt), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .pc_in(pc_in), .if_id_pc(if_id_pc),
    .if_id_instr(if_id_instr), .if_id_valid(if_id_valid),
    .fetch_count(fetch_count), .bubble_count(bubble_count),
    .misalign_err(misalign_err), .fetch_state(fetch_state)
  );

  typedef struct {
    logic        st, ht, rv;
    logic [31:0] tgt;
    logic [31:0] e_pc_in;
    logic [31:0] e_if_pc;
    logic        e_valid;
    logic [31:0] e_fetch;
    logic [15:0] e_bubble;
    logic [1:0]  e_state;
    logic        e_mis;
  } vec_t;

  vec_t vecs[22];

  function automatic vec_t mk(input logic st, ht, rv, input logic [31:0] tgt, pci, ifpc,
                              input logic v, input logic [31:0] fc, input logic [15:0] bc,
                              input logic [1:0] s, input logic m);
    vec_t r;
    r.st = st; r.ht = ht; r.rv = rv; r.tgt = tgt; r.e_pc_in = pci; r.e_if_pc = ifpc;
    r.e_valid = v; r.e_fetch = fc; r.e_bubble = bc; r.e_state = s; r.e_mis = m;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic st, ht, rv, input logic [31:0] tgt);
    stall = st; halt = ht; redirect_valid = rv; redirect_target = tgt;
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  localparam logic [1:0] S_BOOT = 2'd0, S_RUN = 2'd1, S_HALT = 2'd2;

  initial begin
    reset = 1'b1; ovr_en = 1'b0; ovr_val = 32'd0;
    drive(0, 0, 0, 32'd0);

    //            st ht rv tgt          pc_in        if_pc        v fetch bub state  mis
    vecs[0]  = mk(0, 0, 0, 32'h0,       32'h4,       32'h0,       1, 1, 0, S_RUN,  0);
    vecs[1]  = mk(0, 0, 0, 32'h0,       32'h8,       32'h4,       1, 2, 0, S_RUN,  0);
    vecs[2]  = mk(0, 0, 0, 32'h0,       32'hC,       32'h8,       1, 3, 0, S_RUN,  0);
    vecs[3]  = mk(0, 0, 0, 32'h0,       32'h10,      32'hC,       1, 4, 0, S_RUN,  0);
    vecs[4]  = mk(0, 0, 1, 32'h8,       32'h8,       32'hC,       0, 4, 1, S_RUN,  0);
    vecs[5]  = mk(1, 0, 0, 32'h0,       32'h8,       32'hC,       0, 4, 2, S_RUN,  0);
    vecs[6]  = mk(1, 0, 0, 32'h0,       32'h8,       32'hC,       0, 4, 3, S_RUN,  0);
    vecs[7]  = mk(1, 0, 0, 32'h0,       32'h8,       32'hC,       0, 4, 4, S_RUN,  0);
    vecs[8]  = mk(0, 0, 0, 32'h0,       32'hC,       32'h8,       1, 5, 4, S_RUN,  0);
    vecs[9]  = mk(0, 0, 0, 32'h0,       32'h10,      32'hC,       1, 6, 4, S_RUN,  0);
    vecs[10] = mk(1, 1, 1, 32'h100,     32'h100,     32'hC,       0, 6, 5, S_RUN,  0);
    vecs[11] = mk(0, 0, 0, 32'h0,       32'h104,     32'h100,     1, 7, 5, S_RUN,  0);
    vecs[12] = mk(0, 0, 1, 32'h14,      32'h14,      32'h100,     0, 7, 6, S_RUN,  0);
    vecs[13] = mk(0, 1, 0, 32'h0,       32'h14,      32'h100,     0, 7, 6, S_HALT, 0);
    vecs[14] = mk(1, 0, 0, 32'h0,       32'h14,      32'h100,     0, 7, 6, S_HALT, 0);
    vecs[15] = mk(0, 1, 0, 32'h0,       32'h14,      32'h100,     0, 7, 6, S_HALT, 0);
    vecs[16] = mk(1, 1, 0, 32'h0,       32'h14,      32'h100,     0, 7, 6, S_HALT, 0);
    vecs[17] = mk(0, 0, 0, 32'h0,       32'h14,      32'h100,     0, 7, 6, S_HALT, 0);
    vecs[18] = mk(0, 0, 0, 32'h0,       32'h14,      32'h100,     0, 7, 6, S_HALT, 0);
    vecs[19] = mk(0, 0, 1, 32'h43,      32'h40,      32'h100,     0, 7, 7, S_RUN,  1);
    vecs[20] = mk(0, 0, 0, 32'h0,       32'h44,      32'h40,      1, 8, 7, S_RUN,  1);
    vecs[21] = mk(0, 1, 0, 32'h0,       32'h44,      32'h40,      0, 8, 7, S_HALT, 1);

    tick; tick;
    chk("reset_pc_in", pc_in, 32'h0);
    chk("reset_state", {30'd0, fetch_state}, {30'd0, S_BOOT});
    chk("reset_valid", {31'd0, if_id_valid}, 32'd0);
    chk("reset_instr", if_id_instr, 32'd0);

    // BOOT cycle ignores everything, including a redirect.
    reset = 1'b0;
    drive(1, 1, 1, 32'h200);
    #3;
    chk("boot_pc_in", pc_in, 32'h0);
    chk("boot_state", {30'd0, fetch_state}, {30'd0, S_BOOT});
    tick;
    chk("boot_exit_state", {30'd0, fetch_state}, {30'd0, S_RUN});
    chk("boot_exit_valid", {31'd0, if_id_valid}, 32'd0);
    chk("boot_exit_bubble", {16'd0, bubble_count}, 32'd0);

    for (int i = 0; i < 22; i++) begin
      drive(vecs[i].st, vecs[i].ht, vecs[i].rv, vecs[i].tgt);
      #3;
      chk($sformatf("v%0d_pc_in", i), pc_in, vecs[i].e_pc_in);
      tick;
      chk($sformatf("v%0d_if_pc", i), if_id_pc, vecs[i].e_if_pc);
      chk($sformatf("v%0d_instr", i), if_id_instr, imem(vecs[i].e_if_pc));
      chk($sformatf("v%0d_valid", i), {31'd0, if_id_valid}, {31'd0, vecs[i].e_valid});
      chk($sformatf("v%0d_fetch", i), fetch_count, vecs[i].e_fetch);
      chk($sformatf("v%0d_bubble", i), {16'd0, bubble_count}, {16'd0, vecs[i].e_bubble});
      chk($sformatf("v%0d_state", i), {30'd0, fetch_state}, {30'd0, vecs[i].e_state});
      chk($sformatf("v%0d_mis", i), {31'd0, misalign_err}, {31'd0, vecs[i].e_mis});
    end

    // One-cycle reset while HALTED with the sticky error set.
    reset = 1'b1;
    drive(0, 0, 1, 32'h80);
    #3;
    chk("rst_halt_pc_in", pc_in, 32'h0);
    tick;
    reset = 1'b0;
    drive(0, 0, 0, 32'h0);
    chk("rst_halt_state", {30'd0, fetch_state}, {30'd0, S_BOOT});
    chk("rst_halt_if_pc", if_id_pc, 32'h0);
    chk("rst_halt_instr", if_id_instr, 32'h0);
    chk("rst_halt_valid", {31'd0, if_id_valid}, 32'd0);
    chk("rst_halt_fetch", fetch_count, 32'h0);
    chk("rst_halt_bubble", {16'd0, bubble_count}, 32'd0);
    chk("rst_halt_mis", {31'd0, misalign_err}, 32'd0);
    #3;
    chk("rst_boot_pc_in", pc_in, 32'h0);
    tick;
    chk("rst_run_state", {30'd0, fetch_state}, {30'd0, S_RUN});
    chk("rst_run_valid", {31'd0, if_id_valid}, 32'd0);
    #3;
    chk("rst_first_pc_in", pc_in, 32'h4);
    tick;
    chk("rst_first_valid", {31'd0, if_id_valid}, 32'd1);
    chk("rst_first_if_pc", if_id_pc, 32'h0);
    chk("rst_first_fetch", fetch_count, 32'h1);

    // Top-of-address-space wrap.
    ovr_en = 1'b1; ovr_val = 32'hFFFF_FFFC;
    #3;
    chk("wrap_pc_in", pc_in, 32'h0);
    tick;
    ovr_en = 1'b0;
    chk("wrap_if_pc", if_id_pc, 32'hFFFF_FFFC);
    chk("wrap_instr", if_id_instr, imem(32'hFFFF_FFFC));
    chk("wrap_fetch", fetch_count, 32'h2);

    // Bubble counter saturation via a long stall.
    drive(1, 0, 0, 32'h0);
    for (int i = 0; i < 65534; i++) tick;
    chk("sat_fffe", {16'd0, bubble_count}, 32'h0000_FFFE);
    chk("sat_pc_in_hold", pc_in, pc_out);
    tick;
    chk("sat_ffff", {16'd0, bubble_count}, 32'h0000_FFFF);
    for (int i = 0; i < 3; i++) tick;
    chk("sat_hold", {16'd0, bubble_count}, 32'h0000_FFFF);
    chk("sat_fetch_hold", fetch_count, 32'h2);
    drive(0, 0, 0, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
